writeback_regfile: RTL and testbench

- Y-86 pipeline writeback stage: holds the W pipeline register, owns the 15-entry 64-bit program register file and drives the combinational read ports used by decode.
- Write side of the decode interface: decode reads srcA/srcB and forwards from W_dstE/W_valE and W_dstM/W_valM, which this block sources.
- Also tracks processor status (RUN/HALTED) and counts retired instructions.

---
 rtl/writeback_regfile_pkg.sv | 51 +++++
 rtl/writeback_regfile_rf.sv | 73 +++++++
 rtl/writeback_regfile.sv | 113 +++++++++++
 tb/tb_writeback_regfile.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the Y-86 writeback stage.
//   - processor status codes and instruction codes
//   - register-ID and word types, RNONE / RRSP identifiers
//   - the W pipeline register layout and its bubble value
package writeback_regfile_pkg;

   typedef logic [3:0]  reg_id_t;
   typedef logic [63:0] word_t;
   typedef logic [2:0]  stat_t;

   localparam stat_t SAOK = 3'd1;
   localparam stat_t SHLT = 3'd2;
   localparam stat_t SADR = 3'd3;
   localparam stat_t SINS = 3'd4;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam reg_id_t RNONE = 4'hF;
   localparam reg_id_t RRSP  = 4'h4;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } run_state_e;

   typedef struct packed {
      stat_t      stat;
      logic [3:0] icode;
      word_t      val_e;
      word_t      val_m;
      reg_id_t    dst_e;
      reg_id_t    dst_m;
   } w_reg_t;

   // Contents of an empty W slot: a NOP that writes nothing.
   function automatic w_reg_t w_bubble_f();
      w_reg_t b;
      b.stat  = SAOK;
      b.icode = INOP;
      b.val_e = 64'd0;
      b.val_m = 64'd0;
      b.dst_e = RNONE;
      b.dst_m = RNONE;
      return b;
   endfunction

endpackage

// File: rtl/writeback_regfile_rf.sv
// 15 x 64-bit program register file (r0..r14; ID 4'hF is "no register").
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_we                    global write enable for both write ports
//   i_dst_e/i_val_e         write port E
//   i_dst_m/i_val_m         write port M (wins when both target one register)
//   i_src_a/i_src_b         read IDs; o_rval_a/o_rval_b combinational data
// Macro REGFILE_BYPASS_EN: reads return the value being written this cycle.
module writeback_regfile_rf
   import writeback_regfile_pkg::*;
#(
   parameter word_t STACK_INIT = 64'h0
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_we,
   input  reg_id_t i_dst_e,
   input  word_t   i_val_e,
   input  reg_id_t i_dst_m,
   input  word_t   i_val_m,
   input  reg_id_t i_src_a,
   input  reg_id_t i_src_b,
   output word_t   o_rval_a,
   output word_t   o_rval_b
);

   word_t r_regs [0:14];

   // Single read port lookup; RNONE always reads as zero.
   function automatic word_t read_port(input reg_id_t src);
      word_t v;
      v = 64'd0;
      if (src == RNONE) begin
         v = 64'd0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (i_we && (src == i_dst_m)) begin
         v = i_val_m;
      end
      else if (i_we && (src == i_dst_e)) begin
         v = i_val_e;
      end
`endif
      else begin
         v = r_regs[src];
      end
      return v;
   endfunction

   // Register storage: reset image, then E write followed by M write so M wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 15; i++) begin
            r_regs[i] <= 64'd0;
         end
         r_regs[RRSP] <= STACK_INIT;
      end else if (i_we) begin
         if (i_dst_e != RNONE) begin
            r_regs[i_dst_e] <= i_val_e;
         end
         if (i_dst_m != RNONE) begin
            r_regs[i_dst_m] <= i_val_m;
         end
      end
   end

   // Combinational read ports for decode.
   always_comb begin
      o_rval_a = read_port(i_src_a);
      o_rval_b = read_port(i_src_b);
   end

endmodule

// File: rtl/writeback_regfile.sv
// Y-86 writeback stage: W pipeline register, program register file,
// RUN/HALTED status tracking and retired-instruction counter.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   m_stat, M_icode, M_valE,    memory-stage results latched into W
//   m_valM, M_dstE, M_dstM
//   W_stall, W_bubble           W control (stall has priority)
//   srcA, srcB -> rvalA, rvalB  decode read ports
//   W_icode, W_valE, W_valM,    W register contents (decode forwarding)
//   W_dstE, W_dstM, stat
//   halted, retired             status and retired count
// Macro REGFILE_BYPASS_EN: register reads bypass the pending W write.
module writeback_regfile
   import writeback_regfile_pkg::*;
#(
   parameter word_t STACK_INIT = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  m_stat,
   input  logic [3:0]  M_icode,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic [63:0] rvalA,
   output logic [63:0] rvalB,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] retired
);

   run_state_e r_state;
   w_reg_t     r_w;
   word_t      r_retired;
   logic       w_rf_we;

   // Only a healthy instruction in W, while running, may update registers.
   assign w_rf_we = (r_state == ST_RUN) && (r_w.stat == SAOK);

   // Status FSM, W register and retire counter. A faulting status in W
   // halts the machine and W is held so the faulting code stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_w       <= w_bubble_f();
         r_retired <= 64'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (r_w.stat != SAOK) begin
                  r_state <= ST_HALTED;
               end else if (!W_stall) begin
                  if (r_w.icode != INOP) begin
                     r_retired <= r_retired + 64'd1;
                  end else begin
                     r_retired <= r_retired;
                  end
                  if (W_bubble) begin
                     r_w <= w_bubble_f();
                  end else begin
                     r_w <= '{stat: m_stat, icode: M_icode, val_e: M_valE,
                              val_m: m_valM, dst_e: M_dstE, dst_m: M_dstM};
                  end
               end else begin
                  r_w <= r_w;
               end
            end
            ST_HALTED: begin
               r_state <= ST_HALTED;
            end
            default: begin
               r_state <= ST_HALTED;
            end
         endcase
      end
   end

   writeback_regfile_rf #(
      .STACK_INIT (STACK_INIT)
   ) u_rf (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_we     (w_rf_we),
      .i_dst_e  (r_w.dst_e),
      .i_val_e  (r_w.val_e),
      .i_dst_m  (r_w.dst_m),
      .i_val_m  (r_w.val_m),
      .i_src_a  (srcA),
      .i_src_b  (srcB),
      .o_rval_a (rvalA),
      .o_rval_b (rvalB)
   );

   assign W_icode = r_w.icode;
   assign W_valE  = r_w.val_e;
   assign W_valM  = r_w.val_m;
   assign W_dstE  = r_w.dst_e;
   assign W_dstM  = r_w.dst_m;
   assign stat    = r_w.stat;
   assign halted  = (r_state == ST_HALTED);
   assign retired = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vectors, an instruction-level model
// of the writeback stage, a per-cycle compare and hand-computed literals.
module tb_writeback_regfile;

   localparam logic [63:0] TB_STACK = 64'h0000_0000_0001_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  m_stat;
   logic [3:0]  M_icode;
   logic [63:0] M_valE;
   logic [63:0] m_valM;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic        W_stall;
   logic        W_bubble;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] rvalA;
   logic [63:0] rvalB;
   logic [3:0]  W_icode;
   logic [63:0] W_valE;
   logic [63:0] W_valM;
   logic [3:0]  W_dstE;
   logic [3:0]  W_dstM;
   logic [2:0]  stat;
   logic        halted;
   logic [63:0] retired;

   writeback_regfile #(.STACK_INIT(TB_STACK)) dut (
      .clk(clk), .rst_n(rst_n), .m_stat(m_stat), .M_icode(M_icode),
      .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble), .srcA(srcA), .srcB(srcB),
      .rvalA(rvalA), .rvalB(rvalB), .W_icode(W_icode), .W_valE(W_valE),
      .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM), .stat(stat),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: architectural registers, the instruction sitting in W, status.
   logic [63:0] m_regs [0:14];
   logic [2:0]  mw_stat;
   logic [3:0]  mw_icode;
   logic [63:0] mw_vale;
   logic [63:0] mw_valm;
   logic [3:0]  mw_dste;
   logic [3:0]  mw_dstm;
   bit          m_halted;
   logic [63:0] m_retired;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_regs[4] = TB_STACK;
      mw_stat = 3'd1; mw_icode = 4'h1; mw_vale = 64'd0; mw_valm = 64'd0;
      mw_dste = 4'hF; mw_dstm = 4'hF;
      m_halted = 1'b0;
      m_retired = 64'd0;
   endtask

   function automatic logic [63:0] exp_read(input logic [3:0] src);
      if (src == 4'hF) return 64'd0;
`ifdef REGFILE_BYPASS_EN
      if (!m_halted && mw_stat == 3'd1) begin
         if (mw_dstm == src) return mw_valm;
         if (mw_dste == src) return mw_vale;
      end
`endif
      return m_regs[src];
   endfunction

   // One clock edge at the instruction level: the instruction in W retires
   // (its results land in the register file, popq-style M result last),
   // then the next instruction moves from M into W.
   task automatic model_step();
      if (rst_n !== 1'b1 || m_halted) return;
      if (mw_stat != 3'd1) begin
         m_halted = 1'b1;
         return;
      end
      if (mw_dste != 4'hF) m_regs[mw_dste] = mw_vale;
      if (mw_dstm != 4'hF) m_regs[mw_dstm] = mw_valm;
      if (!W_stall) begin
         if (mw_icode != 4'h1) m_retired = m_retired + 64'd1;
         if (W_bubble) begin
            mw_stat = 3'd1; mw_icode = 4'h1; mw_vale = 64'd0; mw_valm = 64'd0;
            mw_dste = 4'hF; mw_dstm = 4'hF;
         end else begin
            mw_stat = m_stat; mw_icode = M_icode; mw_vale = M_valE;
            mw_valm = m_valM; mw_dste = M_dstE; mw_dstm = M_dstM;
         end
      end
   endtask

   task automatic compare_all();
      chk("W_icode", W_icode, mw_icode);
      chk("W_valE",  W_valE,  mw_vale);
      chk("W_valM",  W_valM,  mw_valm);
      chk("W_dstE",  W_dstE,  mw_dste);
      chk("W_dstM",  W_dstM,  mw_dstm);
      chk("stat",    stat,    mw_stat);
      chk("halted",  halted,  m_halted);
      chk("retired", retired, m_retired);
      chk("rvalA",   rvalA,   exp_read(srcA));
      chk("rvalB",   rvalB,   exp_read(srcB));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         compare_all();
      end
   end

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_m(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
      m_stat = s; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
   endtask

   task automatic set_nop();
      set_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      set_nop();
      W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'hF; srcB = 4'hF;
      nxt(); nxt();
      rst_n = 1'b1;

      // Write r3, then reset mid-run
      set_m(3'd1, 4'h3, 64'h33, 64'd0, 4'h3, 4'hF); nxt();
      set_nop(); nxt();
      srcA = 4'h3; #1;
      chk("lit_r3_written", rvalA, 64'h33);
      rst_n = 1'b0; model_reset(); #1;
      chk("lit_rst_icode", W_icode, 64'h1);
      chk("lit_rst_dstE", W_dstE, 64'hF);
      chk("lit_rst_retired", retired, 64'd0);
      chk("lit_rst_halted", halted, 64'd0);
      chk("lit_rst_r3", rvalA, 64'd0);
      srcA = 4'h4; #1;
      chk("lit_rst_rsp", rvalA, TB_STACK);
      nxt();
      rst_n = 1'b1;

      // irmovq $0x1234, %rdx
      set_m(3'd1, 4'h3, 64'h1234, 64'd0, 4'h2, 4'hF); nxt();
      chk("lit_irmov_dstE", W_dstE, 64'h2);
      set_nop(); srcA = 4'h2; nxt();
      chk("lit_irmov_r2", rvalA, 64'h1234);
      chk("lit_irmov_retired", retired, 64'd1);

      // popq %rsp: M result wins over E result
      set_m(3'd1, 4'hB, 64'h100, 64'hABCD, 4'h4, 4'h4); nxt();
      set_nop(); srcB = 4'h4; nxt();
      chk("lit_popq_rsp", rvalB, 64'hABCD);
      chk("lit_popq_retired", retired, 64'd2);

      // mrmovq into r6, then three stalled edges (one also with bubble)
      set_m(3'd1, 4'h5, 64'h40, 64'h5555, 4'hF, 4'h6); nxt();
      chk("lit_mrmov_icode", W_icode, 64'h5);
      W_stall = 1'b1;
      set_m(3'd1, 4'h6, 64'h77, 64'd0, 4'h7, 4'hF);
      for (int i = 0; i < 3; i++) begin
         W_bubble = (i == 1);
         nxt();
         chk("lit_stall_icode", W_icode, 64'h5);
         chk("lit_stall_retired", retired, 64'd2);
      end
      W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'h6; nxt();
      chk("lit_unstall_retired", retired, 64'd3);
      chk("lit_unstall_icode", W_icode, 64'h6);
      chk("lit_r6", rvalA, 64'h5555);
      W_bubble = 1'b1; srcA = 4'h7; nxt();
      chk("lit_bubble_icode", W_icode, 64'h1);
      chk("lit_bubble_dstM", W_dstM, 64'hF);
      chk("lit_r7", rvalA, 64'h77);
      W_bubble = 1'b0; set_nop(); nxt();
      chk("lit_bubble_not_counted", retired, 64'd4);

      // two-register popq: E and M targets differ
      set_m(3'd1, 4'hB, 64'h88, 64'h99, 4'h8, 4'h9); nxt();
      set_nop(); srcA = 4'h8; srcB = 4'h9; nxt();
      chk("lit_r8", rvalA, 64'h88);
      chk("lit_r9", rvalB, 64'h99);
      chk("lit_retired5", retired, 64'd5);

      // halt, then later AOK instruction must not land
      set_m(3'd2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF); nxt();
      chk("lit_hlt_stat", stat, 64'd2);
      chk("lit_hlt_not_yet", halted, 64'd0);
      set_m(3'd1, 4'h3, 64'h999, 64'd0, 4'h1, 4'hF); nxt();
      chk("lit_hlt_halted", halted, 64'd1);
      nxt(); nxt();
      srcA = 4'h1; #1;
      chk("lit_hlt_r1", rvalA, 64'd0);
      chk("lit_hlt_retired", retired, 64'd5);
      chk("lit_hlt_stat_held", stat, 64'd2);

      // ADR fault with dstM=5
      rst_n = 1'b0; model_reset(); nxt();
      rst_n = 1'b1;
      set_m(3'd3, 4'h5, 64'd0, 64'hDEAD, 4'hF, 4'h5); nxt();
      chk("lit_adr_stat", stat, 64'd3);
      set_nop(); nxt(); nxt();
      srcA = 4'h5; #1;
      chk("lit_adr_r5", rvalA, 64'd0);
      chk("lit_adr_halted", halted, 64'd1);
      chk("lit_adr_stat_held", stat, 64'd3);
      rst_n = 1'b0; model_reset(); #1;
      chk("lit_adr_rst_stat", stat, 64'd1);
      chk("lit_adr_rst_halted", halted, 64'd0);
      nxt();
      rst_n = 1'b1;
      nxt(); nxt();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
